awgn_clt_gen: RTL

Central-limit Gaussian sample generator sitting directly downstream of the 32-bit Tausworthe uniform generator in the AWGN chain. It consumes uniform 32-bit words over a valid/ready handshake and splits each word into two 16-bit unsigned uniforms. It sums 2·N_WORDS of them, removes the mean, then scales and saturates the result into a signed fixed-point noise sample. Output goes to the noise-injection stage over valid/ready.

---
 rtl/awgn_pkg.sv | 24 ++
 rtl/awgn_clt_gen_sat_shift.sv | 36 +++
 rtl/awgn_clt_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN noise chain.
//   state_e    : sample-generator FSM states
//   WORD_MEAN  : mean of (hi + lo) for one uniform 32-bit word
//   acc_width  : accumulator width needed for a given word count
//   DEF_OUT_W, DEF_SHIFT : default output width and scale shift
package awgn_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_e;

  // Two 16-bit uniforms each with mean 32767.5, so one word contributes exactly 65535.
  localparam int unsigned WORD_MEAN = 65535;

  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 5;

  // One word adds at most 2*65535 (17 bits); one extra bit keeps the sum unsigned-safe.
  function automatic int acc_width(input int n_words);
    return 18 + $clog2(n_words);
  endfunction

endpackage

// File: rtl/awgn_clt_gen_sat_shift.sv
// sat_shift: arithmetic right shift (floor) followed by saturation to a signed
// OUT_W result.
//   din_i  : signed input, IN_W bits
//   dout_o : signed scaled and clipped result, OUT_W bits
//   sat_o  : 1 when the scaled value did not fit and was clipped
module sat_shift #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16,
  parameter int SHIFT = 5
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    sat_o
);

  logic signed [IN_W-1:0] scaled;

  assign scaled = din_i >>> SHIFT;

  if (IN_W > OUT_W) begin : g_clip
    logic [IN_W-OUT_W:0] top_bits;
    logic                clip;

    // Fits in OUT_W iff the discarded bits plus the new sign bit are all equal.
    assign top_bits = scaled[IN_W-1:OUT_W-1];
    assign clip     = !((&top_bits) || !(|top_bits));
    assign sat_o    = clip;
    assign dout_o   = !clip            ? scaled[OUT_W-1:0] :
                      scaled[IN_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                         {1'b0, {(OUT_W-1){1'b1}}};
  end else begin : g_wide
    assign sat_o  = 1'b0;
    assign dout_o = OUT_W'(scaled);
  end

endmodule

// File: rtl/awgn_clt_gen.sv
// awgn_clt_gen: central-limit Gaussian generator. Sums 2*N_WORDS 16-bit
// uniforms taken from N_WORDS 32-bit words, removes the exact mean, scales by
// an arithmetic right shift and saturates to a signed OUT_W sample.
//   clk, reset (async, active-low)
//   in_data/in_valid/in_ready    : uniform word input handshake
//   out_data/out_valid/out_ready : Gaussian sample output handshake
//   out_sat                      : sample was clipped (qualified by out_valid)
//
// state | meaning
// ACCUM | collecting words, no sample held, always ready for input
// OUT   | sample held on output; input accepted only while downstream takes it
module awgn_clt_gen
  import awgn_pkg::*;
#(
  parameter int N_WORDS = 6,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT   = DEF_SHIFT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat
);

  localparam int ACC_W = acc_width(N_WORDS);
  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_WORDS - 1);
  localparam logic signed [ACC_W:0] MEAN_SUM = (ACC_W+1)'(N_WORDS * WORD_MEAN);

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    sat_q, sat_d;

  logic [16:0]             word_sum;
  logic [ACC_W-1:0]        sum;
  logic signed [ACC_W:0]   centred;
  logic signed [OUT_W-1:0] scaled;
  logic                    scaled_sat;
  logic                    accept;

  assign word_sum = {1'b0, in_data[31:16]} + {1'b0, in_data[15:0]};
  assign sum      = acc_q + ACC_W'(word_sum);
  assign centred  = $signed({1'b0, sum}) - MEAN_SUM;

  sat_shift #(
    .IN_W (ACC_W + 1),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_sat_shift (
    .din_i (centred),
    .dout_o(scaled),
    .sat_o (scaled_sat)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    sat_d    = sat_q;
    in_ready = (state_q == ACCUM) ? 1'b1 : out_ready;
    accept   = in_valid && in_ready;

    if (state_q == OUT && out_ready) state_d = ACCUM;

    // A completing accept in OUT can only happen while the old sample is
    // being consumed, so loading the new result here never drops one.
    if (accept) begin
      if (cnt_q == LAST_CNT) begin
        data_d  = scaled;
        sat_d   = scaled_sat;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = OUT;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = data_q;
  assign out_sat   = sat_q;

endmodule
